// File: rtl/bch15_7_encoder_seq.sv
// Sequential systematic BCH(15,7) encoder, g(x) = x^8 + x^7 + x^6 + x^4 + 1.
// Accepts a 7-bit message on a valid/ready handshake. An LFSR computes the
// 8 parity bits, one bit per clock. The codeword is streamed serially, MSB
// (x^14) first, and is also presented as a registered 15-bit word under a
// second valid/ready handshake.
//
// Ports:
//   i_Clk       clock, rising edge
//   i_Rst       asynchronous active-high reset
//   i_Message   7-bit message, bit 6 = coefficient of x^14
//   i_MsgValid  message offered
//   o_MsgReady  encoder idle and able to accept a message
//   o_SerData   serial codeword bit
//   o_SerValid  o_SerData valid this cycle
//   o_CodeWord  {message, parity}
//   o_CwValid   o_CodeWord valid, held until i_CwReady
//   i_CwReady   consumer takes o_CodeWord
module bch15_7_encoder_seq #(
  parameter logic [7:0] P_GPOLY = 8'hD1
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [6:0]  i_Message,
  input  logic        i_MsgValid,
  output logic        o_MsgReady,
  output logic        o_SerData,
  output logic        o_SerValid,
  output logic [14:0] o_CodeWord,
  output logic        o_CwValid,
  input  logic        i_CwReady
);

  localparam int unsigned MSG_W = 7;
  localparam int unsigned PAR_W = 8;
  localparam int unsigned CW_W  = MSG_W + PAR_W;
  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] PARITY_LAST = CNT_W'(PAR_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAR_W-1:0]   r_q, r_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [PAR_W-1:0]   par_q, par_d;
  logic [CW_W-1:0]    cw_q, cw_d;
  logic               cw_valid_q, cw_valid_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_valid_q, ser_valid_d;
  logic               msg_ready_q, msg_ready_d;

  // Message bit for the current SHIFT cycle and for the one after it.
  logic [2:0]         bit_idx;
  logic [2:0]         nxt_idx;
  logic               fb;
  logic [PAR_W-1:0]   r_shift;

  assign bit_idx = 3'(4'd6 - cnt_q);
  assign nxt_idx = 3'(4'd5 - cnt_q);
  assign fb      = msg_q[bit_idx] ^ r_q[PAR_W-1];
  assign r_shift = {r_q[PAR_W-2:0], 1'b0} ^ (fb ? P_GPOLY : PAR_W'(0));

  // State and datapath registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      msg_q       <= '0;
      par_q       <= '0;
      cw_q        <= '0;
      cw_valid_q  <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      msg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      msg_q       <= msg_d;
      par_q       <= par_d;
      cw_q        <= cw_d;
      cw_valid_q  <= cw_valid_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      msg_ready_q <= msg_ready_d;
    end
  end

  // Next-state logic; serial outputs are precomputed for the coming cycle so
  // that every output is a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    msg_d       = msg_q;
    par_d       = par_q;
    cw_d        = cw_q;
    cw_valid_d  = cw_valid_q;
    ser_data_d  = 1'b0;
    ser_valid_d = 1'b0;
    msg_ready_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_MsgValid) begin
          msg_d       = i_Message;
          r_d         = '0;
          cnt_d       = '0;
          state_d     = S_SHIFT;
          ser_valid_d = 1'b1;
          ser_data_d  = i_Message[MSG_W-1];
        end else begin
          msg_ready_d = 1'b1;
        end
      end

      S_SHIFT: begin
        r_d         = r_shift;
        ser_valid_d = 1'b1;
        if (cnt_q == SHIFT_LAST) begin
          // Remainder is final here; its MSB is the first parity bit out.
          cnt_d      = '0;
          par_d      = r_shift;
          ser_data_d = r_shift[PAR_W-1];
          state_d    = S_PARITY;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          ser_data_d = msg_q[nxt_idx];
        end
      end

      S_PARITY: begin
        r_d = {r_q[PAR_W-2:0], 1'b0};
        if (cnt_q == PARITY_LAST) begin
          cnt_d      = '0;
          cw_d       = {msg_q, par_q};
          cw_valid_d = 1'b1;
          state_d    = S_HOLD;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          ser_valid_d = 1'b1;
          ser_data_d  = r_q[PAR_W-2];
        end
      end

      S_HOLD: begin
        if (i_CwReady) begin
          cw_valid_d  = 1'b0;
          msg_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        msg_ready_d = 1'b1;
      end
    endcase
  end

  assign o_MsgReady = msg_ready_q;
  assign o_SerData  = ser_data_q;
  assign o_SerValid = ser_valid_q;
  assign o_CodeWord = cw_q;
  assign o_CwValid  = cw_valid_q;

endmodule

// File: tb/tb_bch15_7_encoder_seq.sv
// Self-checking bench for bch15_7_encoder_seq: directed vectors, hold and
// back-to-back handshakes, mid-stream reset and random messages checked
// against a polynomial long-division reference model.
module tb_bch15_7_encoder_seq;

  logic        i_Clk;
  logic        i_Rst;
  logic [6:0]  i_Message;
  logic        i_MsgValid;
  logic        o_MsgReady;
  logic        o_SerData;
  logic        o_SerValid;
  logic [14:0] o_CodeWord;
  logic        o_CwValid;
  logic        i_CwReady;

  int n_tests;
  int n_fail;

  bch15_7_encoder_seq #(.P_GPOLY(8'hD1)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Message  (i_Message),
    .i_MsgValid (i_MsgValid),
    .o_MsgReady (o_MsgReady),
    .o_SerData  (o_SerData),
    .o_SerValid (o_SerValid),
    .o_CodeWord (o_CodeWord),
    .o_CwValid  (o_CwValid),
    .i_CwReady  (i_CwReady)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Systematic codeword {m, (m(x)*x^8) mod g(x)} by long division over GF(2).
  function automatic logic [14:0] ref_cw(input logic [6:0] m);
    logic [14:0] rem;
    logic [14:0] g;
    rem = {m, 8'h00};
    g   = 15'h01D1;
    for (int i = 14; i >= 8; i--)
      if (rem[i]) rem = rem ^ (g << (i - 8));
    return {m, rem[7:0]};
  endfunction

  // One full transaction from IDLE; hold = extra cycles i_CwReady stays low.
  task automatic encode(input logic [6:0] m, input logic [14:0] exp, input int hold);
    logic [14:0] ser;
    ser = '0;
    check("rdy_idle", 32'(o_MsgReady), 32'd1);
    i_Message  = m;
    i_MsgValid = 1'b1;
    i_CwReady  = (hold == 0);
    @(negedge i_Clk);
    i_MsgValid = 1'b0;
    i_Message  = 7'($urandom);
    check("rdy_busy", 32'(o_MsgReady), 32'd0);
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge i_Clk);
      check("ser_valid", 32'(o_SerValid), 32'd1);
      check("cw_valid_early", 32'(o_CwValid), 32'd0);
      ser[14-k] = o_SerData;
    end
    check("serial", 32'(ser), 32'(exp));
    @(negedge i_Clk);
    check("ser_valid_off", 32'(o_SerValid), 32'd0);
    check("cw_valid", 32'(o_CwValid), 32'd1);
    check("codeword", 32'(o_CodeWord), 32'(exp));
    for (int k = 0; k < hold; k++) begin
      i_MsgValid = 1'($urandom);
      i_Message  = 7'($urandom);
      @(negedge i_Clk);
      check("cw_hold_valid", 32'(o_CwValid), 32'd1);
      check("cw_hold_word", 32'(o_CodeWord), 32'(exp));
      check("rdy_hold", 32'(o_MsgReady), 32'd0);
      check("ser_hold", 32'(o_SerValid), 32'd0);
    end
    i_MsgValid = 1'b0;
    i_CwReady  = 1'b1;
    @(negedge i_Clk);
    check("cw_valid_drop", 32'(o_CwValid), 32'd0);
    check("rdy_after", 32'(o_MsgReady), 32'd1);
    check("cw_keep", 32'(o_CodeWord), 32'(exp));
    i_CwReady = 1'b0;
  endtask

  logic        sv [1:34];
  logic        sd [1:34];
  logic        cv [1:34];
  logic        mr [1:34];
  logic [14:0] cw16, cw33, ser1, ser2;
  int          nsv;
  logic        saw_valid;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    i_Rst      = 1'b1;
    i_Message  = '0;
    i_MsgValid = 1'b0;
    i_CwReady  = 1'b0;
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    @(negedge i_Clk);
    check("rst_ready", 32'(o_MsgReady), 32'd1);
    check("rst_cwvalid", 32'(o_CwValid), 32'd0);
    check("rst_servalid", 32'(o_SerValid), 32'd0);
    check("rst_serdata", 32'(o_SerData), 32'd0);
    check("rst_codeword", 32'(o_CodeWord), 32'd0);

    encode(7'b0000000, 15'b000000000000000, 0);
    encode(7'b0000001, 15'b000000111010001, 1);
    encode(7'b1011001, 15'b101100100011110, 0);
    encode(7'b1111111, 15'h7FFF, 10);

    // Back-to-back: valid and ready held high, two messages 17 cycles apart.
    i_Message  = 7'b0000001;
    i_MsgValid = 1'b1;
    i_CwReady  = 1'b1;
    cw16 = '0; cw33 = '0; ser1 = '0; ser2 = '0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge i_Clk);
      if (c == 1) i_Message = 7'b1011001;
      sv[c] = o_SerValid;
      sd[c] = o_SerData;
      cv[c] = o_CwValid;
      mr[c] = o_MsgReady;
      if (c == 16) cw16 = o_CodeWord;
      if (c == 33) cw33 = o_CodeWord;
      if (c == 34) i_MsgValid = 1'b0;
    end
    i_CwReady = 1'b0;
    for (int c = 1; c <= 15; c++) ser1[15-c] = sd[c];
    for (int c = 18; c <= 32; c++) ser2[32-c] = sd[c];
    nsv = 0;
    for (int c = 1; c <= 17; c++) nsv += int'(sv[c]);
    check("b2b_sv_cnt1", 32'(nsv), 32'd15);
    nsv = 0;
    for (int c = 18; c <= 34; c++) nsv += int'(sv[c]);
    check("b2b_sv_cnt2", 32'(nsv), 32'd15);
    check("b2b_ser1", 32'(ser1), 32'(15'b000000111010001));
    check("b2b_ser2", 32'(ser2), 32'(15'b101100100011110));
    check("b2b_cv16", 32'(cv[16]), 32'd1);
    check("b2b_cv33", 32'(cv[33]), 32'd1);
    check("b2b_cw1", 32'(cw16), 32'(15'b000000111010001));
    check("b2b_cw2", 32'(cw33), 32'(15'b101100100011110));
    check("b2b_rdy17", 32'(mr[17]), 32'd1);
    check("b2b_rdy34", 32'(mr[34]), 32'd1);
    check("b2b_rdy2", 32'(mr[2]), 32'd0);
    @(negedge i_Clk);
    check("b2b_idle", 32'(o_MsgReady), 32'd1);

    // Reset in the fifth SHIFT cycle aborts the transfer.
    i_Message  = 7'b1011001;
    i_MsgValid = 1'b1;
    @(negedge i_Clk);
    i_MsgValid = 1'b0;
    repeat (4) @(negedge i_Clk);
    check("pre_rst_sv", 32'(o_SerValid), 32'd1);
    #2 i_Rst = 1'b1;
    #1;
    check("arst_servalid", 32'(o_SerValid), 32'd0);
    check("arst_serdata", 32'(o_SerData), 32'd0);
    check("arst_cwvalid", 32'(o_CwValid), 32'd0);
    check("arst_codeword", 32'(o_CodeWord), 32'd0);
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_Clk);
      saw_valid = saw_valid | o_CwValid | o_SerValid;
    end
    check("post_rst_quiet", 32'(saw_valid), 32'd0);
    encode(7'b0000001, 15'b000000111010001, 0);

    // Random messages against the reference model.
    for (int t = 0; t < 25; t++) begin
      logic [6:0] m;
      m = 7'($urandom);
      encode(m, ref_cw(m), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
